mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the picorv32 native memory bus (mem_valid/mem_ready).
//  Sits beside the on-chip RAM in the top-level memory decoder; decodes its own 16-byte window.
//  Firmware pushes bytes into a TX FIFO; the block serialises them 8N1, LSB first, on uart_tx.
// PARAMETERS
//  BASE_ADDR    32'h1000_0000  window base; window is addr[31:4]==BASE_ADDR[31:4]
//  FIFO_DEPTH   8              TX FIFO entries; power of two, >=2
//  DIV_WIDTH    16             width of baud divisor register
//  DEFAULT_DIV  104            divisor after reset (clk cycles per bit)
// PORTS
//  clk        in   1          clock; all logic on posedge
//  reset      in   1          asynchronous, active-high reset
//  mem_valid  in   1          bus request valid
//  mem_addr   in   32         byte address
//  mem_wdata  in   32         write data
//  mem_wstrb  in   4          byte write strobes; 0000 = read
//  mem_ready  out  1          one-cycle response pulse for in-window requests
//  mem_rdata  out  32         read data; valid while mem_ready=1, else 0
//  uart_tx    out  1          serial output, idles high
//  irq_empty  out  1          high when FIFO empty, shifter idle, and IE=1
// BEHAVIOUR
//  Reset: mem_ready=0, mem_rdata=0, uart_tx=1, FIFO empty, OVF=0, IE=0, DIV=DEFAULT_DIV, FSM=IDLE.
//  Reset mid-frame aborts the frame; uart_tx goes high asynchronously and queued bytes are lost.
//  Bus: request is registered. mem_ready asserts the cycle after mem_valid && in-window && !mem_ready.
//   One pulse per request. Side effects commit on the same edge that raises mem_ready.
//   Out-of-window requests get no response and no side effects.
//  Register map (offset = addr[3:2]):
//   0x0 TXDATA: write with wstrb[0] pushes wdata[7:0]. Write when full drops the byte and sets OVF. Reads return 0.
//   0x4 STATUS: read {23'b0, IE[8], LEVEL[7:4], OVF[3], BUSY[2], FULL[1], EMPTY[0]}.
//       Write: wstrb[0]&&wdata[3] clears OVF; wstrb[1] loads IE from wdata[8].
//       LEVEL is a 4-bit count saturating at 15.
//   0x8 DIV: read/write, zero-extended; byte lanes 0/1 obey wstrb. Value 0 behaves as 1.
//   0xC: reserved; reads return 0 and mem_ready pulses as normal; writes are ignored.
//  FIFO: FULL is evaluated before that cycle's pop.
//   Push and pop in the same cycle are both honoured and LEVEL is unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: if FIFO is not empty, pop into the shifter and go to START.
//   START: tx=0. DATA: bits 0..7, LSB first, bit counter 0..7. STOP: tx=1 for one bit period.
//   At the end of STOP, a non-empty FIFO pops directly and goes to START; there is no idle bit.
//   Each bit lasts exactly max(DIV,1) clk cycles, counted by a baud counter that reloads per bit.
//   A DIV write takes effect at the next bit boundary; the bit in progress is unaffected.
//   BUSY=1 in any state other than IDLE.
//   A byte pushed into an empty FIFO while IDLE produces the start bit 2 cycles after the push edge.
//   uart_tx is registered (glitch-free).
//  irq_empty is registered from EMPTY && !BUSY && IE.
// TESTING
//  1 Reset, then read STATUS -> 0x0000_0001; read DIV -> 104; uart_tx=1; no response to addr 0x1000_0010.
//  2 DIV=4, write 0x55 to TXDATA -> start bit low 4 clk, then 1,0,1,0,1,0,1,0, then stop high;
//    the frame is 40 clk and BUSY clears after the stop bit.
//  3 DIV=2, 10 back-to-back TXDATA writes with the line busy -> LEVEL=8, FULL=1, OVF=1;
//    first 9 bytes transmitted contiguously, 10th lost; writing 0x8 to STATUS clears OVF.
//  4 Push when LEVEL=1 on the edge where the FSM pops -> LEVEL stays 1 and no byte is lost or duplicated.
//  5 DIV write 4->8 mid-DATA -> current bit keeps 4 clk, following bits take 8 clk.
//  6 Assert reset mid-DATA with 3 bytes queued -> uart_tx=1 immediately, STATUS=0x1 after release,
//    nothing transmitted. Write IE=1 -> irq_empty=1 the next cycle.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: picorv32 native-bus UART transmitter.
// 16-byte register window, TX FIFO and an 8N1 serialiser.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          DIV_WIDTH   = 16,
    parameter int          DEFAULT_DIV = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        irq_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]        P_ONE  = AW'(1);
    localparam logic [AW:0]          C_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]          C_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] D_ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] D_RST  = DIV_WIDTH'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;
    logic                 r_ovf;
    logic                 r_ie;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_ready;
    logic [31:0]          r_rdata;
    logic                 r_irq;
    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_baud;
    logic [2:0]           r_bitcnt;
    logic [7:0]           r_shift;
    logic                 r_tx;

    logic                 w_hit;
    logic                 w_req;
    logic                 w_wr;
    logic [1:0]           w_off;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_busy;
    logic [3:0]           w_level;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_ovf_set;
    logic                 w_ovf_clr;
    logic                 w_pop;
    logic                 w_tick;
    logic [DIV_WIDTH-1:0] w_reload;
    logic [DIV_WIDTH-1:0] w_div_new;
    logic [7:0]           w_head;
    logic [31:0]          w_rd_val;
    logic [15:0]          w_unused;

    assign w_hit      = mem_addr[31:4] == BASE_ADDR[31:4];
    assign w_req      = mem_valid && w_hit && !r_ready;
    assign w_wr       = w_req && (mem_wstrb != 4'b0000);
    assign w_off      = mem_addr[3:2];
    assign w_empty    = r_count == '0;
    assign w_full     = r_count == C_FULL;
    assign w_busy     = r_state != S_IDLE;
    assign w_push_req = w_wr && (w_off == 2'd0) && mem_wstrb[0];
    assign w_push     = w_push_req && !w_full;
    assign w_ovf_set  = w_push_req && w_full;
    assign w_ovf_clr  = w_wr && (w_off == 2'd1)
                        && mem_wstrb[0] && mem_wdata[3];
    assign w_tick     = r_baud == '0;
    assign w_reload   = (r_div == '0) ? '0 : r_div - D_ONE;
    assign w_head     = r_mem[r_rptr];
    assign w_pop      = !w_empty
                        && ((r_state == S_IDLE)
                        || ((r_state == S_STOP) && w_tick));
    assign w_unused   = {mem_addr[1:0], mem_wstrb[3:2],
                         mem_wdata[31:20]};

    always_comb begin
        w_level = 4'(r_count);
        if (32'(r_count) > 32'd15) begin
            w_level = 4'hF;
        end
    end

    always_comb begin
        w_div_new = r_div;
        if (mem_wstrb[0]) begin
            w_div_new[7:0] = mem_wdata[7:0];
        end
        if (mem_wstrb[1]) begin
            w_div_new[15:8] = mem_wdata[15:8];
        end
    end

    always_comb begin
        w_rd_val = '0;
        unique case (1'b1)
            w_off == 2'd1: w_rd_val = {23'b0, r_ie, w_level, r_ovf,
                                       w_busy, w_full, w_empty};
            w_off == 2'd2: w_rd_val = 32'(r_div);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_ovf   <= 1'b0;
            r_ie    <= 1'b0;
            r_div   <= D_RST;
            r_irq   <= 1'b0;
        end else begin
            r_ready <= w_req;
            r_rdata <= (w_req && (mem_wstrb == 4'b0000)) ? w_rd_val : '0;
            r_irq   <= w_empty && !w_busy && r_ie;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && (w_off == 2'd1) && mem_wstrb[1]) begin
                r_ie <= mem_wdata[8];
            end
            if (w_wr && (w_off == 2'd2)) begin
                r_div <= w_div_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + P_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + P_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - C_ONE;
            end
        end
    end

    // uart_tx trails the state by one cycle, so every bit keeps its length
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_tx <= (r_state == S_START) ? 1'b0 :
                    (r_state == S_DATA)  ? r_shift[0] : 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_baud  <= w_reload;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_baud   <= w_reload;
                        r_bitcnt <= '0;
                        r_state  <= S_DATA;
                    end else begin
                        r_baud <= r_baud - D_ONE;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_baud <= w_reload;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - D_ONE;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (!w_empty) begin
                            r_shift <= w_head;
                            r_baud  <= w_reload;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - D_ONE;
                    end
                end
            endcase
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign uart_tx   = r_tx;
    assign irq_empty = r_irq;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and random bus traffic checked
// every cycle against a queue/frame model of the UART.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] A_TX  = BASE + 32'h0;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_DIV = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        irq_empty;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_uart_tx dut (
        .clk(clk),
        .reset(reset),
        .mem_valid(mem_valid),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .uart_tx(uart_tx),
        .irq_empty(irq_empty)
    );

    always #5 clk = ~clk;

    // Model: byte queue plus the 10-bit frame being sent
    logic [7:0]  q[$];
    logic [15:0] m_div = 16'd104;
    logic        m_ie = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_active = 1'b0;
    logic [9:0]  m_frame = '0;
    int          m_bit = 0;
    int          m_left = 0;
    logic        m_line = 1'b1;
    logic        exp_ready = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic        exp_tx = 1'b1;
    logic        exp_irq = 1'b0;
    int          mn;
    int          md;
    logic        mreq;
    logic        mpop;
    logic [1:0]  moff;
    logic [31:0] mrv;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_div = 16'd104; m_ie = 0; m_ovf = 0;
            m_active = 0; m_bit = 0; m_left = 0;
            m_line = 1; exp_ready = 0; exp_rdata = 0;
            exp_tx = 1; exp_irq = 0;
        end else begin
            mn = q.size();
            moff = mem_addr[3:2];
            mreq = mem_valid && (mem_addr[31:4] == BASE[31:4])
                   && !exp_ready;
            mrv = 0;
            if (moff == 2'd1)
                mrv = {23'b0, m_ie, (mn > 15) ? 4'hF : 4'(mn),
                       m_ovf, m_active, mn == 8, mn == 0};
            if (moff == 2'd2) mrv = {16'b0, m_div};
            exp_irq = (mn == 0) && !m_active && m_ie;
            exp_tx = m_line;
            md = (m_div == 0) ? 1 : int'(m_div);
            mpop = 0;
            if (!m_active) begin
                mpop = mn > 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_bit == 9) begin
                        if (mn > 0) mpop = 1;
                        else m_active = 0;
                    end else begin
                        m_bit++;
                        m_left = md;
                    end
                end
            end
            if (mpop) begin
                m_frame = {1'b1, q.pop_front(), 1'b0};
                m_active = 1; m_bit = 0; m_left = md;
            end
            m_line = m_active ? m_frame[m_bit] : 1'b1;
            exp_ready = mreq;
            exp_rdata = (mreq && mem_wstrb == 0) ? mrv : 0;
            if (mreq && mem_wstrb != 0) begin
                if (moff == 2'd0 && mem_wstrb[0]) begin
                    if (mn == 8) m_ovf = 1;
                    else q.push_back(mem_wdata[7:0]);
                end
                if (moff == 2'd1) begin
                    if (mem_wstrb[0] && mem_wdata[3]) m_ovf = 0;
                    if (mem_wstrb[1]) m_ie = mem_wdata[8];
                end
                if (moff == 2'd2) begin
                    if (mem_wstrb[0]) m_div[7:0] = mem_wdata[7:0];
                    if (mem_wstrb[1]) m_div[15:8] = mem_wdata[15:8];
                end
            end
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if ({mem_ready, mem_rdata, uart_tx, irq_empty} !==
            {exp_ready, exp_rdata, exp_tx, exp_irq}) begin
            n_bad++;
            $display("FAIL cycle t=%0t: ready %b rdata %h tx %b irq %b, required %b %h %b %b",
                     $time, mem_ready, mem_rdata, uart_tx, irq_empty,
                     exp_ready, exp_rdata, exp_tx, exp_irq);
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        int k;
        mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_valid = 1;
        k = 0;
        do begin
            @(posedge clk); @(negedge clk); k++;
        end while (!mem_ready && k < 4);
        check("bus_ready", {31'b0, mem_ready}, 32'd1);
        rd = mem_rdata;
        mem_valid = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] rd;
        bus(a, d, s, rd);
    endtask

    task automatic oow(input logic [31:0] a);
        mem_addr = a; mem_wdata = $urandom;
        mem_wstrb = 4'($urandom_range(0, 15)); mem_valid = 1;
        @(posedge clk); @(negedge clk);
        check("oow_noready", {31'b0, mem_ready}, 32'd0);
        mem_valid = 0;
    endtask

    task automatic drain(input string nm);
        logic [31:0] rd;
        int k;
        k = 0;
        do begin
            bus(A_ST, 0, 4'b0000, rd); k++;
        end while ((rd & 32'h7) != 32'h1 && k < 600);
        check(nm, rd & 32'h7, 32'h1);
    endtask

    logic        rec [0:127];
    logic [9:0]  fr;
    logic [31:0] rd;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  off;
    int          f;
    int          k;
    int          idx;
    int          op;
    int          zeros;
    logic        wrote;

    task automatic first_low(output int fi);
        fi = -1;
        for (int j = 0; j < 128; j++)
            if (fi < 0 && rec[j] == 1'b0) fi = j;
    endtask

    initial begin
        #1 reset = 1;
        repeat (3) @(negedge clk);
        #2 reset = 0;
        @(negedge clk);
        check("reset_tx", {31'b0, uart_tx}, 32'd1);
        check("reset_ready", {31'b0, mem_ready}, 32'd0);
        bus(A_ST, 0, 4'b0000, rd);  check("reset_status", rd, 32'h1);
        bus(A_DIV, 0, 4'b0000, rd); check("reset_div", rd, 32'd104);
        bus(A_RSV, 0, 4'b0000, rd); check("rsv_read", rd, 32'h0);
        bus(A_TX, 0, 4'b0000, rd);  check("txdata_read", rd, 32'h0);
        oow(32'h1000_0010);

        wr(A_DIV, 32'd4, 4'b0011);
        wr(A_TX, 32'h55, 4'b0001);
        for (int j = 0; j < 64; j++) begin
            @(negedge clk); rec[j] = uart_tx;
        end
        first_low(f);
        check("start_latency", f, 1);
        fr = {1'b1, 8'h55, 1'b0};
        for (int j = 0; j < 40; j++)
            check("frame55", {31'b0, rec[f + j]}, {31'b0, fr[j / 4]});
        check("frame55_end", {31'b0, rec[f + 40]}, 32'd1);
        bus(A_ST, 0, 4'b0000, rd); check("idle_status", rd, 32'h1);

        wr(A_DIV, 32'd2, 4'b0011);
        for (int j = 0; j < 10; j++) wr(A_TX, 32'hA0 + j, 4'b0001);
        bus(A_ST, 0, 4'b0000, rd); check("full_status", rd, 32'h8E);
        wr(A_ST, 32'h8, 4'b0001);
        bus(A_ST, 0, 4'b0000, rd); check("ovf_cleared", rd, 32'h74);
        drain("drain_overflow");

        wr(A_TX, 32'h11, 4'b0001);
        wr(A_TX, 32'h22, 4'b0001);
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (!(m_active && m_bit == 9 && m_left == 1 && !mem_ready)
                   && k < 200);
        check("stop_edge_found", {31'b0, k < 200}, 32'd1);
        wr(A_TX, 32'h33, 4'b0001);
        bus(A_ST, 0, 4'b0000, rd); check("pushpop_level", rd, 32'h14);
        drain("drain_pushpop");

        wr(A_DIV, 32'd4, 4'b0011);
        wr(A_TX, 32'h55, 4'b0001);
        wrote = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk); rec[j] = uart_tx;
            if (mem_valid && mem_ready) begin
                mem_valid = 0;
            end else if (!wrote && m_active && m_bit == 3
                         && m_left == 3 && !mem_ready) begin
                mem_addr = A_DIV; mem_wdata = 32'd8;
                mem_wstrb = 4'b0011; mem_valid = 1; wrote = 1;
            end
        end
        check("div_written", {31'b0, wrote}, 32'd1);
        first_low(f);
        check("start_latency2", f, 1);
        for (int j = 0; j < 64; j++) begin
            idx = (j < 16) ? j / 4 : 4 + (j - 16) / 8;
            check("div_change", {31'b0, rec[f + j]}, {31'b0, fr[idx]});
        end
        check("div_change_end", {31'b0, rec[f + 64]}, 32'd1);

        for (int j = 1; j <= 4; j++) wr(A_TX, j, 4'b0001);
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (!(m_active && m_bit == 4) && k < 300);
        check("line_low_before_reset", {31'b0, uart_tx}, 32'd0);
        #2 reset = 1;
        #1 check("async_reset_tx", {31'b0, uart_tx}, 32'd1);
        @(negedge clk); @(negedge clk);
        #2 reset = 0;
        @(negedge clk);
        bus(A_ST, 0, 4'b0000, rd);  check("post_reset_status", rd, 32'h1);
        bus(A_DIV, 0, 4'b0000, rd); check("post_reset_div", rd, 32'd104);
        zeros = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk); if (!uart_tx) zeros++;
        end
        check("nothing_sent", zeros, 0);
        wr(A_ST, 32'h100, 4'b0010);
        check("irq_not_yet", {31'b0, irq_empty}, 32'd0);
        @(negedge clk);
        check("irq_set", {31'b0, irq_empty}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end else if (op == 1) begin
                oow(BASE + 32'($urandom_range(1, 15)) * 32'h10);
            end else begin
                off = (op < 6) ? 2'd0 : 2'($urandom_range(1, 3));
                s = ($urandom_range(0, 2) == 0) ? 4'b0 :
                    4'($urandom_range(1, 15));
                d = $urandom;
                if (off == 2'd2) d = {24'b0, 8'($urandom_range(0, 5))};
                bus(BASE + {28'b0, off, 2'b00}, d, s, rd);
            end
        end
        k = 0;
        do begin
            @(negedge clk); k++;
        end while ((m_active || q.size() != 0) && k < 20000);
        drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end
endmodule
